// File: rtl/matrix_fifo_pkg.sv
// matrix_fifo_pkg
// Shared sizing constants and types for the image-filter line-buffer FIFO.
// DEPTH is derived from DEPTH_WIDTH; the *_DEF values are the default
// almost-full / almost-empty thresholds used by the top-level parameters.
package matrix_fifo_pkg;

    localparam int DATA_WIDTH           = 8;
    localparam int DEPTH_WIDTH          = 12;
    localparam int DEPTH                = 1 << DEPTH_WIDTH;
    localparam int ALMOST_FULL_NUM_DEF  = 1020;
    localparam int ALMOST_EMPTY_NUM_DEF = 4;

    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [DEPTH_WIDTH-1:0] addr_t;
    // Pointers and occupancy carry one extra bit: wrap bit / count of DEPTH.
    typedef logic [DEPTH_WIDTH:0]   ptr_t;

endpackage

// File: rtl/matrix_fifo_buffer_if.sv
// matrix_fifo_buffer_if
// Write/read handshake bundle of the line-buffer FIFO.
//   wr_data, wr_en          : write request from the upstream stage
//   wr_full, almost_full    : write-side status
//   rd_en                   : read request from the downstream stage
//   rd_data                 : read data (registered)
//   rd_empty, almost_empty  : read-side status
// master = the stage driving the FIFO, slave = the FIFO itself.
interface matrix_fifo_buffer_if;
    import matrix_fifo_pkg::*;

    data_t wr_data;
    logic  wr_en;
    logic  wr_full;
    logic  almost_full;
    logic  rd_en;
    data_t rd_data;
    logic  rd_empty;
    logic  almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

endinterface

// File: rtl/matrix_fifo_ram.sv
// matrix_fifo_ram
// Simple dual-port RAM, DEPTH x DATA_WIDTH, inferred (no vendor primitives).
//   clk        : clock
//   rst        : synchronous reset of the read-data register only
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe; rd_data_o updates on the same edge
//   rd_addr_i  : read address
//   rd_data_o  : registered read data, holds between reads
// Array contents are never cleared.
module matrix_fifo_ram
    import matrix_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en_i,
    input  addr_t wr_addr_i,
    input  data_t wr_data_i,
    input  logic  rd_en_i,
    input  addr_t rd_addr_i,
    output data_t rd_data_o
);

    data_t mem_q [DEPTH];
    data_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/matrix_fifo_buffer.sv
// matrix_fifo_buffer
// Single-clock 8-bit x 4096-entry FIFO used as a line buffer in the
// Gaussian-matrix image filter. Strict FIFO order, registered flags.
//   clk  : clock
//   rst  : synchronous active-high reset (pointers, count, flags, rd_data)
//   bus  : matrix_fifo_buffer_if.slave (write/read handshake and flags)
// Parameters: ALMOST_FULL_NUM (almost_full when count >= it),
//             ALMOST_EMPTY_NUM (almost_empty when count <= it).
// Build option: MATRIX_FIFO_OUTPUT_REG_EN adds an output pipeline register
// after the RAM, making read latency 2 cycles; flags are unaffected.
module matrix_fifo_buffer
    import matrix_fifo_pkg::*;
#(
    parameter int ALMOST_FULL_NUM  = ALMOST_FULL_NUM_DEF,
    parameter int ALMOST_EMPTY_NUM = ALMOST_EMPTY_NUM_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_fifo_buffer_if.slave  bus
);

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t count_q, count_d;
    logic wr_full_q, wr_full_d;
    logic rd_empty_q, rd_empty_d;
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;
    logic wr_acc;
    logic rd_acc;
    data_t ram_rd_data;

    // Acceptance uses the registered flags, so a read on a full FIFO cannot
    // free a slot for a same-cycle write, and a write into an empty FIFO
    // cannot fall through to a same-cycle read.
    assign wr_acc = bus.wr_en && !wr_full_q;
    assign rd_acc = bus.rd_en && !rd_empty_q;

    always_comb begin
        wptr_d  = wptr_q + ptr_t'(wr_acc);
        rptr_d  = rptr_q + ptr_t'(rd_acc);
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ptr_t'(1);
            2'b01:   count_d = count_q - ptr_t'(1);
            default: count_d = count_q;
        endcase
        wr_full_d      = (count_d == ptr_t'(DEPTH));
        rd_empty_d     = (count_d == '0);
        almost_full_d  = (count_d >= ptr_t'(ALMOST_FULL_NUM));
        almost_empty_d = (count_d <= ptr_t'(ALMOST_EMPTY_NUM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            wr_full_q      <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            wr_full_q      <= wr_full_d;
            rd_empty_q     <= rd_empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Reset blocks RAM writes so an in-flight request is not stored while
    // the pointers are being cleared.
    matrix_fifo_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc && !rst),
        .wr_addr_i (wptr_q[DEPTH_WIDTH-1:0]),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (rd_acc && !rst),
        .rd_addr_i (rptr_q[DEPTH_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

`ifdef MATRIX_FIFO_OUTPUT_REG_EN
    logic  rd_vld_q;
    data_t rd_out_q;

    // Only load after an accepted read so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_out_q <= '0;
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_vld_q) begin
                rd_out_q <= ram_rd_data;
            end
        end
    end

    assign bus.rd_data = rd_out_q;
`else
    assign bus.rd_data = ram_rd_data;
`endif

    assign bus.wr_full      = wr_full_q;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;

endmodule

// File: tb/tb_matrix_fifo_buffer.sv
// tb_matrix_fifo_buffer
// Self-checking bench for matrix_fifo_buffer (default build, 1-cycle read
// latency). Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point, i.e. after the edge that acted on them.
module tb_matrix_fifo_buffer;
    import matrix_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    matrix_fifo_buffer_if bus ();

    matrix_fifo_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic       rd_en;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic       exp_empty;
        logic       exp_aempty;
        logic       exp_full;
        logic       exp_afull;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e, input logic ae,
                             input logic f, input logic af);
        chk({tag, ".rd_empty"},     32'(bus.rd_empty),     32'(e));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        chk({tag, ".wr_full"},      32'(bus.wr_full),      32'(f));
        chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(af));
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = 8'h00;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle();
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] exp_d;
        int         cnt;

        vecs[0]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h33, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h44, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h55, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h66, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h77, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h88, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held 20 cycles.
        idle();
        #1;
        do_reset(20);
        step();
        chk_flags("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset.rd_data", 32'(bus.rd_data), 32'h0);

        // Directed vectors from the empty state.
        for (int i = 0; i < 13; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.rd_en   = vecs[i].rd_en;
            bus.wr_data = vecs[i].wd;
            step();
            chk($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_rd));
            chk_flags($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_aempty,
                      vecs[i].exp_full, vecs[i].exp_afull);
        end

        // Fill: 4097 writes counting down from 0xFF; the last one is dropped.
        do_reset(3);
        for (int k = 1; k <= 4097; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(255 - (k - 1));
            step();
            cnt = (k > 4096) ? 4096 : k;
            chk_flags($sformatf("fill%0d", k), 1'b0, cnt <= 4, cnt == 4096, cnt >= 1020);
        end
        idle();

        // Drain: 4097 reads; the last one is ignored and rd_data holds 0x00.
        for (int i = 1; i <= 4097; i++) begin
            bus.rd_en = 1'b1;
            step();
            exp_d = (i <= 4096) ? 8'(255 - (i - 1)) : 8'h00;
            cnt   = 4096 - ((i > 4096) ? 4096 : i);
            chk($sformatf("drain%0d.rd_data", i), 32'(bus.rd_data), 32'(exp_d));
            chk_flags($sformatf("drain%0d", i), cnt == 0, cnt <= 4, 1'b0, cnt >= 1020);
        end
        idle();

        // Simultaneous read and write at count 10 for 100 cycles.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i + 16);
            q.push_back(8'(i + 16));
            step();
        end
        for (int j = 0; j < 100; j++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = 1'b1;
            bus.wr_data = 8'(8'h80 + j);
            exp_d = q.pop_front();
            q.push_back(8'(8'h80 + j));
            step();
            chk($sformatf("rw%0d.rd_data", j), 32'(bus.rd_data), 32'(exp_d));
            chk_flags($sformatf("rw%0d", j), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        q.delete();

        // Full plus read plus write: read accepted, write dropped.
        do_reset(2);
        for (int k = 0; k < 4096; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(k);
            step();
        end
        chk("full.wr_full", 32'(bus.wr_full), 32'h1);
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hEE;
        step();
        chk("fullrw.rd_data", 32'(bus.rd_data), 32'h00);
        chk_flags("fullrw", 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        bus.rd_en = 1'b1;
        repeat (4095) step();
        chk("fulldrain.rd_data", 32'(bus.rd_data), 32'hFF);
        chk_flags("fulldrain", 1'b1, 1'b1, 1'b0, 1'b0);
        idle();

        // Empty plus write plus read: write accepted, read ignored.
        do_reset(2);
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        chk("emptyrw.rd_data", 32'(bus.rd_data), 32'h00);
        chk_flags("emptyrw", 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        bus.rd_en = 1'b1;
        step();
        chk("emptyrw_rd.rd_data", 32'(bus.rd_data), 32'hA5);
        chk_flags("emptyrw_rd", 1'b1, 1'b1, 1'b0, 1'b0);
        idle();

        // Reset at count 2000, with requests active during reset.
        for (int k = 0; k < 2000; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(k + 3);
            step();
        end
        bus.rd_en = 1'b1;
        step();
        chk("pre_rst.almost_full", 32'(bus.almost_full), 32'h1);
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hC3;
        repeat (2) step();
        rst = 1'b0;
        idle();
        step();
        chk_flags("midrst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst.rd_data", 32'(bus.rd_data), 32'h00);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        step();
        idle();
        bus.rd_en = 1'b1;
        step();
        chk("midrst_new.rd_data", 32'(bus.rd_data), 32'h5A);
        chk_flags("midrst_new", 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        step();
        chk("midrst_hold.rd_data", 32'(bus.rd_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
